// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types, mode constants and sizing helper for addsub_serial
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Digit counter width; a single-digit operation still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// rtl/addsub_serial_if.sv - operand/result handshake bundle for addsub_serial
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, mode, sat, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, mode, sat, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-bit ripple adder built from full-adder cells
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_top
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout  = c[DIGIT];
    // Carry into the slice MSB; on the last slice this is the carry into bit WIDTH-1.
    assign c_top = c[DIGIT-1];
endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement add/sub with carry, overflow, zero and saturation
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    addsub_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t state, state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             sat_r;
    logic             carry;
    logic [CW-1:0]    count;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic [DIGIT-1:0] x_d;
    logic [DIGIT-1:0] y_d;
    logic [DIGIT-1:0] sum_d;
    logic             cout_d;
    logic             ctop_d;
    logic             last;
    logic             sub;
    logic             ovf_n;
    int               base;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] fin;

    assign sub  = (bus.mode == MODE_SUB);
    assign last = (count == CW'(N - 1));
    assign base = int'(count) * DIGIT;
    assign x_d  = a_r[base +: DIGIT];
    assign y_d  = b_r[base +: DIGIT];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (x_d),
        .y     (y_d),
        .cin   (carry),
        .sum   (sum_d),
        .cout  (cout_d),
        .c_top (ctop_d)
    );

    // Final result is resolved on the last slice so s and flags are registered and hold in DONE.
    always_comb begin
        raw              = s_r;
        raw[base +: DIGIT] = sum_d;
    end

    assign ovf_n   = ctop_d ^ cout_d;
    assign sat_val = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign fin     = (sat_r && ovf_n) ? sat_val : raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            sat_r  <= 1'b0;
            carry  <= 1'b0;
            count  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b ^ {WIDTH{sub}};
                        sat_r <= bus.sat;
                        carry <= sub;
                        count <= '0;
                    end
                end
                RUN: begin
                    carry <= cout_d;
                    count <= count + 1'b1;
                    if (last) begin
                        s_r    <= fin;
                        cout_r <= cout_d;
                        ovf_r  <= ovf_n;
                        zero_r <= (fin == '0);
                    end else begin
                        s_r <= raw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s    = s_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes on input and output. It processes one DIGIT-bit slice per cycle, LSB first, and reports carry, signed overflow and zero flags. Optional signed saturation is available per operation. It replaces the fixed 4-bit combinational add/sub wherever area matters more than latency, and sits between operand producers and result consumers in the datapath.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per cycle; WIDTH % DIGIT == 0 is required (elaboration error otherwise).
- Derived: N = WIDTH/DIGIT, the cycles per operation.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a, b  in  WIDTH  operands.
- mode  in  1  0 = a+b, 1 = a−b (b inverted, carry-in = 1).
- sat  in  1  1 = clamp the result to the signed range on overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow of the unsaturated result.
- zero  out  1  s == 0, evaluated after saturation.

## Operation
- FSM states: IDLE, RUN, DONE.
- **Reset** forces IDLE. Reset values: s = 0, cout = ovf = zero = out_valid = 0, in_ready = 1. The internal digit counter and carry are cleared. An operation in flight is discarded with no output.
- **IDLE:** in_ready = 1. On in_valid && in_ready:
  - latch a, b ^ {WIDTH{mode}}, and sat;
  - carry ← mode, count ← 0;
  - go to RUN.
- **RUN:** each cycle adds one DIGIT slice (index count) of the latched operands plus carry.
  - Write the slice result into the s shift/result register; carry ← slice carry-out; count++.
  - On the slice with count == N−1, also capture the carry into bit WIDTH−1 (c_msb).
  - After slice N−1, go to DONE.
- **DONE:** out_valid = 1, and s and the flags are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- **Flags:**
  - cout = final carry.
  - ovf = c_msb ^ cout.
  - If sat && ovf: s = latched a[WIDTH−1] ? {1'b1, {WIDTH−1{1'b0}}} : {1'b0, {WIDTH−1{1'b1}}}. Otherwise s = raw sum.
  - zero = (final s == 0).
- Inputs outside IDLE are ignored. in_valid seen while busy is not queued.
- All arithmetic is modulo 2^WIDTH. There is no sign extension and no carry-in port.

## Timing
- Accept at edge k → RUN on edges k+1 … k+N → out_valid high from just after edge k+N. Latency is N cycles from the accepting edge to out_valid.
- Earliest next accept: the edge after the output handshake. in_ready rises in the cycle after out_valid && out_ready (no overlap).
- Throughput: one op per N+2 cycles with out_ready held high.
- DIGIT == WIDTH (N = 1) is legal: one RUN cycle.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready to either.
- Backpressure: DONE may persist indefinitely. s and the flags must not change while out_valid && !out_ready.
- Reset asserted in any state takes effect immediately (async). Deassertion must be synchronised externally to clk.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1;
  - a function computing counter width, $clog2(N) with a minimum of 1.
- Sub-module addsub_digit: a combinational DIGIT-bit ripple adder built from full-adder cells.
  - Inputs: x[DIGIT], y[DIGIT], cin.
  - Outputs: sum[DIGIT], cout, c_top (the carry into the slice MSB, used for ovf on the last slice).
- Top level: FSM, counter, operand/result registers, flag and saturation logic.

## Test plan
All scenarios use WIDTH = 16, DIGIT = 4, so N = 4.

- **Add:** a = 0x1234, b = 0x0FFF, mode = 0, sat = 0 → s = 0x2233, cout = 0, ovf = 0, zero = 0. out_valid rises exactly 4 cycles after the accept edge.
- **Subtract with borrow:** a = 0x0005, b = 0x0007, mode = 1 → s = 0xFFFE, cout = 0, ovf = 0.
- **Positive overflow:** 0x7FFF + 0x0001.
  - sat = 0 → s = 0x8000, ovf = 1, cout = 0.
  - Repeat with sat = 1 → s = 0x7FFF, ovf = 1.
- **Negative overflow, saturated:** a = 0x8000, b = 0x0001, mode = 1, sat = 1 → s = 0x8000 (clamped), ovf = 1, cout = 1, zero = 0.
- **Backpressure:** a = 0x0001, b = 0x0001, mode = 1 → s = 0x0000, zero = 1, cout = 1.
  - Hold out_ready = 0 for 5 cycles: s and flags stable, in_ready = 0.
  - Pulse in_valid during the hold with different operands: ignored, result unchanged.
- **Reset mid-run:** assert rst after 2 RUN cycles → out_valid = 0 and in_ready = 1 immediately. No stale result ever appears. A following op 0x00FF + 0x0001 yields s = 0x0100.
